enkel_computer: RTL and testbench



---
 rtl/enkel_pkg.sv | 40 ++++
 rtl/enkel_computer_ram.sv | 35 +++
 rtl/enkel_computer.sv | 169 ++++++++++++++++
 tb/tb_enkel_computer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enkel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : enkel_pkg
// Purpose : Shared definitions for the enkel accumulator computer: opcode
//           encodings, the HALT argument, the control FSM state type and a
//           helper that forms the RAM operand address from an instruction
//           argument.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package enkel_pkg;

    // Instruction = {op[2:0], arg[4:0]}
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_GET  = 3'b010;
    localparam logic [2:0] OP_PUT  = 3'b011;
    localparam logic [2:0] OP_FEED = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_JMPB = 3'b110;
    localparam logic [2:0] OP_SYS  = 3'b111;

    // OP_SYS with this argument halts; any other argument means SHOW.
    localparam logic [4:0] HALT_ARG = 5'h1F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Memory operands live on 8-byte boundaries: the 5-bit argument selects
    // one of 32 slots spread across the 256-byte RAM.
    function automatic logic [7:0] operand_addr(input logic [4:0] arg);
        return {arg, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/enkel_computer_ram.sv
`default_nettype none
// ============================================================================
// Module  : ram_256x8
// Purpose : Single-port RAM, synchronous write and asynchronous
//           (combinational) read. Contents are not affected by reset.
// Ports   : clk      - write clock
//           i_we     - write enable
//           i_addr   - read/write address
//           i_wdata  - write data
//           o_rdata  - combinational read data at i_addr
// Revision: 1.0 - initial release
// ============================================================================
module ram_256x8 #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/enkel_computer.sv
`default_nettype none
// ============================================================================
// Module  : enkel_computer
// Purpose : 8-bit accumulator computer with a built-in 256x8 RAM and an
//           external programmer port. prog_sel=0 gives the RAM to the
//           programmer and freezes the CPU; prog_sel=1 gives it to the CPU,
//           which starts fetching from address 0 when trigger is seen in
//           IDLE. Every instruction takes one FETCH and one EXEC cycle.
// Ports   : clk, reset_n (async, active-low)
//           trigger                  - run request, sampled in IDLE
//           prog_sel                 - RAM owner: 0=programmer, 1=CPU
//           prog_addr/wdata/we       - programmer RAM access
//           prog_rdata               - async read at the muxed address
//           show_out                 - display register
//           carry, status            - carry flag, 1=halted
//           pc, acc, breg, ir        - debug views of CPU registers
// Revision: 1.0 - initial release
// ============================================================================
module enkel_computer
    import enkel_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trigger,
    input  logic          prog_sel,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_wdata,
    input  logic          prog_we,
    output logic [DW-1:0] prog_rdata,
    output logic [DW-1:0] show_out,
    output logic          carry,
    output logic          status,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] breg,
    output logic [DW-1:0] ir
);

    state_t        r_state;
    state_t        w_state_next;

    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_breg;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_show;
    logic          r_carry;
    logic          r_status;

    logic [2:0]    w_op;
    logic [4:0]    w_arg;
    logic          w_is_halt;
    logic [DW:0]   w_sum;

    logic [AW-1:0] w_cpu_addr;
    logic          w_cpu_we;
    logic [AW-1:0] w_ram_addr;
    logic          w_ram_we;
    logic [DW-1:0] w_ram_wdata;
    logic [DW-1:0] w_rdata;

    assign w_op      = r_ir[7:5];
    assign w_arg     = r_ir[4:0];
    assign w_is_halt = (w_op == OP_SYS) && (w_arg == HALT_ARG);
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_breg};

    // CPU drives the instruction address in FETCH and the operand address in
    // EXEC. The write strobe depends on r_state, which resets asynchronously,
    // so a reset during EXEC of PUT drops the strobe before the next edge.
    assign w_cpu_addr = (r_state == EXEC) ? AW'(operand_addr(w_arg)) : r_pc;
    assign w_cpu_we   = (r_state == EXEC) && (w_op == OP_PUT);

    assign w_ram_addr  = prog_sel ? w_cpu_addr : prog_addr;
    assign w_ram_we    = prog_sel ? w_cpu_we   : prog_we;
    assign w_ram_wdata = prog_sel ? r_acc      : prog_wdata;

    ram_256x8 #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // Programmer ownership freezes the sequencer wherever it is.
        if (prog_sel) begin
            case (r_state)
                IDLE:    if (trigger) w_state_next = FETCH;
                FETCH:   w_state_next = EXEC;
                EXEC:    w_state_next = w_is_halt ? HALT : FETCH;
                HALT:    w_state_next = HALT;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= '0;
            r_acc    <= '0;
            r_breg   <= '0;
            r_ir     <= '0;
            r_show   <= '0;
            r_carry  <= 1'b0;
            r_status <= 1'b0;
        end else if (prog_sel) begin
            case (r_state)
                FETCH: begin
                    r_ir <= w_rdata;
                    r_pc <= r_pc + AW'(1);
                end
                EXEC: begin
                    case (w_op)
                        OP_ADD:  {r_carry, r_acc} <= w_sum;
                        OP_NOT:  r_acc  <= ~r_breg;
                        OP_GET:  r_breg <= w_rdata;
                        OP_FEED: r_breg <= DW'(w_arg);
                        OP_LD:   r_acc  <= r_breg;
                        // pc already points past the JMPB, so the offset is
                        // relative to the following instruction.
                        OP_JMPB: if (r_carry) r_pc <= r_pc + AW'(r_breg);
                        OP_SYS: begin
                            if (w_arg == HALT_ARG) begin
                                r_status <= 1'b1;
                            end else begin
                                r_show <= r_acc;
                            end
                        end
                        default: ; // OP_PUT: RAM write via w_cpu_we
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign prog_rdata = w_rdata;
    assign show_out   = r_show;
    assign carry      = r_carry;
    assign status     = r_status;
    assign pc         = r_pc;
    assign acc        = r_acc;
    assign breg       = r_breg;
    assign ir         = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_enkel_computer.sv
`default_nettype none
// ============================================================================
// Module  : tb_enkel_computer
// Purpose : Self-checking bench for enkel_computer. Expected values are
//           queued when stimulus is applied and popped for comparison when
//           the DUT reaches the point where the result is visible.
// Revision: 1.0 - initial release
// ============================================================================
module tb_enkel_computer;

    logic       clk;
    logic       reset_n;
    logic       trigger;
    logic       prog_sel;
    logic [7:0] prog_addr;
    logic [7:0] prog_wdata;
    logic       prog_we;
    logic [7:0] prog_rdata;
    logic [7:0] show_out;
    logic       carry;
    logic       status;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [7:0] breg;
    logic [7:0] ir;

    int n_total = 0;
    int n_bad   = 0;

    typedef enum int {K_PC, K_ACC, K_BREG, K_IR, K_SHOW, K_CARRY, K_STATUS, K_RDATA} kind_t;
    typedef struct {
        kind_t      kind;
        string      name;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    enkel_computer #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .prog_sel   (prog_sel),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_we    (prog_we),
        .prog_rdata (prog_rdata),
        .show_out   (show_out),
        .carry      (carry),
        .status     (status),
        .pc         (pc),
        .acc        (acc),
        .breg       (breg),
        .ir         (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input kind_t k, input string nm, input logic [7:0] e);
        sb_t s;
        s.kind = k;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
    endfunction

    function automatic logic [7:0] observe(input kind_t k);
        case (k)
            K_PC:     return pc;
            K_ACC:    return acc;
            K_BREG:   return breg;
            K_IR:     return ir;
            K_SHOW:   return show_out;
            K_CARRY:  return {7'd0, carry};
            K_STATUS: return {7'd0, status};
            default:  return prog_rdata;
        endcase
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        trigger  = 1'b0;
        prog_sel = 1'b0;
        prog_we  = 1'b0;
        reset_n  = 1'b0;
        step(2);
        reset_n  = 1'b1;
        step(1);
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [7:0] d);
        prog_sel   = 1'b0;
        prog_addr  = a;
        prog_wdata = d;
        prog_we    = 1'b1;
        step(1);
        prog_we    = 1'b0;
    endtask

    task automatic load_main_prog(input logic [7:0] e0, input logic [7:0] e8);
        logic [7:0] code [0:8];
        code = '{8'h5C, 8'h20, 8'h5D, 8'h00, 8'h81, 8'hC0, 8'hFE, 8'hA0, 8'hFF};
        for (int i = 0; i < 9; i++) prog_write(8'(i), code[i]);
        prog_write(8'hE0, e0);
        prog_write(8'hE8, e8);
    endtask

    task automatic start_cpu();
        prog_sel = 1'b1;
        trigger  = 1'b1;
    endtask

    // Counts clock edges (IDLE edge included) until status rises or budget expires.
    task automatic wait_halt(input int budget, output int cyc);
        cyc = 0;
        while (status !== 1'b1 && cyc < budget) begin
            step(1);
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        sb_t e;
        logic [7:0] obs;
        trigger  = 1'b0;
        prog_sel = 1'b0;
        prog_we  = 1'b0;
        prog_addr = 8'h00;
        prog_wdata = 8'h00;
        reset_n  = 1'b0;
        #1;
        push(K_PC, "rst_pc", 8'h00);      push(K_ACC, "rst_acc", 8'h00);
        push(K_BREG, "rst_breg", 8'h00);  push(K_IR, "rst_ir", 8'h00);
        push(K_SHOW, "rst_show", 8'h00);  push(K_CARRY, "rst_carry", 8'h00);
        push(K_STATUS, "rst_status", 8'h00);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        step(2);
        reset_n = 1'b1;
        // CPU owns RAM but no trigger: must sit in IDLE.
        prog_sel = 1'b1;
        push(K_PC, "idle_pc", 8'h00);
        push(K_IR, "idle_ir", 8'h00);
        step(4);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_program_no_jump();
        sb_t e;
        logic [7:0] obs;
        int cyc;
        do_reset();
        load_main_prog(8'd26, 8'd17);
        push(K_SHOW, "p1_show", 8'hF6);   push(K_ACC, "p1_acc", 8'h01);
        push(K_CARRY, "p1_carry", 8'h00); push(K_STATUS, "p1_status", 8'h01);
        push(K_BREG, "p1_breg", 8'h01);   push(K_PC, "p1_pc", 8'h09);
        start_cpu();
        wait_halt(100, cyc);
        n_total++;
        if (cyc !== 19) begin n_bad++; $display("FAIL p1_cycles: got %0d required %0d", cyc, 19); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_program_jump();
        sb_t e;
        logic [7:0] obs;
        int cyc;
        do_reset();
        load_main_prog(8'd17, 8'd26);
        push(K_SHOW, "p2_show", 8'h00);   push(K_ACC, "p2_acc", 8'h01);
        push(K_CARRY, "p2_carry", 8'h01); push(K_STATUS, "p2_status", 8'h01);
        push(K_PC, "p2_pc", 8'h09);
        start_cpu();
        wait_halt(100, cyc);
        n_total++;
        if (cyc !== 17) begin n_bad++; $display("FAIL p2_cycles: got %0d required %0d", cyc, 17); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_put();
        sb_t e;
        logic [7:0] obs;
        int cyc;
        do_reset();
        prog_write(8'h00, 8'h84);
        prog_write(8'h01, 8'hA0);
        prog_write(8'h02, 8'h6A);
        prog_write(8'h03, 8'hFF);
        prog_write(8'h50, 8'hEE);
        prog_write(8'h60, 8'h33);
        push(K_STATUS, "put_status", 8'h01);
        start_cpu();
        // Programmer strobe while the CPU owns RAM must be ignored.
        prog_addr  = 8'h60;
        prog_wdata = 8'h99;
        prog_we    = 1'b1;
        wait_halt(60, cyc);
        prog_we  = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        prog_sel = 1'b0;
        prog_addr = 8'h50;
        push(K_RDATA, "put_mem50", 8'h04);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        prog_addr = 8'h60;
        push(K_RDATA, "put_we_ignored", 8'h33);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_add_not();
        sb_t e;
        logic [7:0] obs;
        logic [7:0] code [0:7];
        int cyc;
        do_reset();
        // FEED0, NOT(acc=FF), FEED1, ADD, SHOW, GET 0x10, NOT, HALT
        code = '{8'h80, 8'h20, 8'h81, 8'h00, 8'hFE, 8'h42, 8'h20, 8'hFF};
        for (int i = 0; i < 8; i++) prog_write(8'(i), code[i]);
        prog_write(8'h10, 8'h5A);
        push(K_ACC, "ovf_acc", 8'h00);
        push(K_CARRY, "ovf_carry", 8'h01);
        push(K_PC, "ovf_pc", 8'h04);
        start_cpu();
        step(9);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        // Hand RAM back to the programmer: CPU must freeze.
        prog_sel = 1'b0;
        push(K_PC, "freeze_pc", 8'h04);
        push(K_IR, "freeze_ir", 8'h00);
        step(3);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        prog_sel = 1'b1;
        push(K_ACC, "not_acc", 8'hA5);    push(K_BREG, "not_breg", 8'h5A);
        push(K_CARRY, "keep_carry", 8'h01); push(K_SHOW, "ovf_show", 8'h00);
        push(K_STATUS, "an_status", 8'h01);
        wait_halt(60, cyc);
        n_total++;
        if (cyc !== 8) begin n_bad++; $display("FAIL an_cycles: got %0d required %0d", cyc, 8); end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_pc_wrap();
        sb_t e;
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 256; i++) prog_write(8'(i), 8'h80 | 8'(i % 32));
        start_cpu();
        step(1);
        trigger = 1'b0;   // dropping trigger must not stop the run
        push(K_PC, "wrap_pc_ff", 8'hFF);
        step(2 * 255);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        push(K_PC, "wrap_pc_00", 8'h00);  push(K_IR, "wrap_ir", 8'h9F);
        push(K_BREG, "wrap_breg", 8'h1F); push(K_STATUS, "wrap_status", 8'h00);
        step(2);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        push(K_PC, "wrap_pc_01", 8'h01);  push(K_IR, "wrap_ir0", 8'h80);
        step(1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_reset_mid_put();
        sb_t e;
        logic [7:0] obs;
        do_reset();
        prog_write(8'h00, 8'h84);
        prog_write(8'h01, 8'hA0);
        prog_write(8'h02, 8'h6A);
        prog_write(8'h03, 8'hFF);
        prog_write(8'h50, 8'hEE);
        push(K_IR, "mid_ir", 8'h6A);
        push(K_ACC, "mid_acc", 8'h04);
        start_cpu();
        step(6);  // now in EXEC of PUT
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        #2;
        reset_n = 1'b0;
        push(K_PC, "mr_pc", 8'h00);     push(K_ACC, "mr_acc", 8'h00);
        push(K_BREG, "mr_breg", 8'h00); push(K_IR, "mr_ir", 8'h00);
        push(K_SHOW, "mr_show", 8'h00); push(K_CARRY, "mr_carry", 8'h00);
        push(K_STATUS, "mr_status", 8'h00);
        step(1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        trigger = 1'b0;
        reset_n = 1'b1;
        push(K_PC, "mr_idle_pc", 8'h00);
        step(3);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
        prog_sel  = 1'b0;
        prog_addr = 8'h50;
        push(K_RDATA, "mr_no_write", 8'hEE);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); obs = observe(e.kind); n_total++;
            if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, obs, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_program_no_jump();
        test_program_jump();
        test_put();
        test_add_not();
        test_pc_wrap();
        test_reset_mid_put();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
